// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse host: controller state encoding,
// PS/2 protocol byte constants and the odd-parity helper used on both the
// transmit and receive paths.
package ps2_pkg;

   typedef enum logic [2:0] {
      StInhibit = 3'd0,
      StReq     = 3'd1,
      StTx      = 3'd2,
      StTxAck   = 3'd3,
      StWaitAck = 3'd4,
      StStream  = 3'd5,
      StWaitId  = 3'd6
   } ps2_state_e;

   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;  // Enable Data Reporting
   localparam logic [7:0] PS2_ACK        = 8'hFA;
   localparam logic [7:0] PS2_BAT_OK     = 8'hAA;  // self-test passed (hot-plug)

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2mouse_host_if.sv
// Bundle of the PS/2 pin-level signals and the decoder-facing byte stream.
//   ps2clk_in / ps2dat_in   raw pin levels (into the host)
//   ps2clk_oe / ps2dat_oe   open-drain pull-low enables (out of the host)
//   data / data_valid       received stream byte and its one-cycle strobe
//   frame_error             one-cycle strobe on a bad frame or bit timeout
//   init_done               high while the host is streaming
// master = the host controller, slave = the pins/decoder side.
interface ps2mouse_host_if;

   logic       ps2clk_in;
   logic       ps2dat_in;
   logic       ps2clk_oe;
   logic       ps2dat_oe;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_error;
   logic       init_done;

   modport master (
      input  ps2clk_in,
      input  ps2dat_in,
      output ps2clk_oe,
      output ps2dat_oe,
      output data,
      output data_valid,
      output frame_error,
      output init_done
   );

   modport slave (
      output ps2clk_in,
      output ps2dat_in,
      input  ps2clk_oe,
      input  ps2dat_oe,
      input  data,
      input  data_valid,
      input  frame_error,
      input  init_done
   );

endinterface

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pin: 2-FF synchronizer followed by a glitch filter.
//   clk, rst_n   system clock, asynchronous active-low reset
//   pin_i        raw pin level
//   level_o      filtered level (idles high, like an undriven PS/2 line)
//   fall_o       one-cycle pulse in the first cycle level_o reads 0 after 1
// The filtered level only follows the synchronized sample after FILTER_LEN
// consecutive samples that differ from the current filtered level.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic level_o,
   output logic fall_o
);

   localparam int unsigned     CntW    = $clog2(FILTER_LEN + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            fall_q, fall_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      fall_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/ps2mouse_host.sv
// PS/2 mouse host line interface feeding the Kempston packet decoder.
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus          ps2mouse_host_if.master: pins in, open-drain enables out,
//                received byte stream, frame_error and init_done out
// After reset the bus is inhibited, 0xF4 is sent and 0xFA awaited; then every
// good frame is forwarded with a one-cycle data_valid. A 0xAA report (hot-plug)
// swallows the following ID byte and restarts the initialisation.
module ps2mouse_host
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned INHIBIT_CYCLES = 2800,
   parameter int unsigned TIMEOUT_CYCLES = 56000
) (
   input  logic            clk,
   input  logic            rst_n,
   ps2mouse_host_if.master bus
);

   localparam int unsigned     InhW    = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   ps2_state_e      state_q, state_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [9:0]      shift_q, shift_d;
   logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            clk_oe_q, clk_oe_d;
   logic            dat_oe_q, dat_oe_d;
   logic [7:0]      data_q, data_d;
   logic            data_valid_q, data_valid_d;
   logic            frame_error_q, frame_error_d;
   logic            init_done_q, init_done_d;

   logic clk_lvl, clk_fall, dat_lvl, dat_fall;
   logic unused_filter_out;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_i   (bus.ps2clk_in),
      .level_o (clk_lvl),
      .fall_o  (clk_fall)
   );

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_dat_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_i   (bus.ps2dat_in),
      .level_o (dat_lvl),
      .fall_o  (dat_fall)
   );

   assign unused_filter_out = clk_lvl ^ dat_fall;

   logic       rx_state, tmr_run, tmo_hit, frame_done, frame_good;
   logic [7:0] rx_byte;

   assign rx_state = state_q inside {StWaitAck, StStream, StWaitId};
   // Timer runs while a frame is in flight, and also while the device owes us
   // clocks or a reply during initialisation.
   assign tmr_run  = (state_q inside {StTx, StTxAck, StWaitAck, StWaitId}) ||
                     (bit_cnt_q != 4'd0);
   // A fall in the expiry cycle counts as a bit, not a timeout.
   assign tmo_hit  = tmr_run && !clk_fall && (tmo_q == TmoLast);

   // shift_q after 10 falls: [0]=start, [8:1]=D7..D0, [9]=parity; stop is live.
   assign frame_done = rx_state && clk_fall && (bit_cnt_q == 4'd10);
   assign rx_byte    = shift_q[8:1];
   assign frame_good = ~shift_q[0] & dat_lvl & (shift_q[9] == odd_parity(rx_byte));

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      inh_cnt_d     = '0;
      tmo_d         = '0;
      dat_oe_d      = 1'b0;
      data_d        = data_q;
      data_valid_d  = 1'b0;
      frame_error_d = 1'b0;

      if (tmr_run && !clk_fall && !tmo_hit) begin
         tmo_d = tmo_q + 1'b1;
      end

      if (rx_state) begin
         if (clk_fall) begin
            if (bit_cnt_q == 4'd10) begin
               bit_cnt_d     = 4'd0;
               frame_error_d = ~frame_good;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               shift_d   = {dat_lvl, shift_q[9:1]};
            end
         end else if (tmo_hit && (bit_cnt_q != 4'd0)) begin
            bit_cnt_d     = 4'd0;
            frame_error_d = 1'b1;
         end
      end

      unique case (state_q)
         StInhibit: begin
            bit_cnt_d = 4'd0;
            // Count only once the clock line is actually held low, so the
            // hold time is exact both out of reset and on a retry.
            if (clk_oe_q) begin
               if (inh_cnt_q == InhLast) begin
                  state_d  = StReq;
                  dat_oe_d = 1'b1;
               end else begin
                  inh_cnt_d = inh_cnt_q + 1'b1;
               end
            end
         end
         StReq: begin
            dat_oe_d = 1'b1;  // start bit stays on the line until the first fall
            state_d  = StTx;
         end
         StTx: begin
            dat_oe_d = dat_oe_q;
            if (clk_fall) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q < 4'd8) begin
                  dat_oe_d = ~PS2_CMD_ENABLE[bit_cnt_q[2:0]];
               end else if (bit_cnt_q == 4'd8) begin
                  dat_oe_d = ~odd_parity(PS2_CMD_ENABLE);
               end else begin
                  dat_oe_d  = 1'b0;  // stop bit: release the line
                  bit_cnt_d = 4'd0;
                  state_d   = StTxAck;
               end
            end else if (tmo_hit) begin
               dat_oe_d  = 1'b0;
               bit_cnt_d = 4'd0;
               state_d   = StInhibit;
            end
         end
         StTxAck: begin
            if (clk_fall) begin
               state_d = dat_lvl ? StInhibit : StWaitAck;
            end else if (tmo_hit) begin
               state_d = StInhibit;
            end
         end
         StWaitAck: begin
            if (frame_done) begin
               state_d = (frame_good && (rx_byte == PS2_ACK)) ? StStream : StInhibit;
            end else if (tmo_hit) begin
               state_d = StInhibit;
            end
         end
         StStream: begin
            if (frame_done && frame_good) begin
               if (rx_byte == PS2_BAT_OK) begin
                  state_d = StWaitId;
               end else begin
                  data_d       = rx_byte;
                  data_valid_d = 1'b1;
               end
            end
         end
         StWaitId: begin
            if ((frame_done && frame_good) || tmo_hit) begin
               state_d = StInhibit;
            end
         end
         default: begin
            state_d = StInhibit;
         end
      endcase

      clk_oe_d    = (state_d == StInhibit);
      init_done_d = (state_d == StStream);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StInhibit;
         bit_cnt_q     <= 4'd0;
         shift_q       <= '0;
         inh_cnt_q     <= '0;
         tmo_q         <= '0;
         clk_oe_q      <= 1'b0;
         dat_oe_q      <= 1'b0;
         data_q        <= 8'h00;
         data_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
         init_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         inh_cnt_q     <= inh_cnt_d;
         tmo_q         <= tmo_d;
         clk_oe_q      <= clk_oe_d;
         dat_oe_q      <= dat_oe_d;
         data_q        <= data_d;
         data_valid_q  <= data_valid_d;
         frame_error_q <= frame_error_d;
         init_done_q   <= init_done_d;
      end
   end

   assign bus.ps2clk_oe   = clk_oe_q;
   assign bus.ps2dat_oe   = dat_oe_q;
   assign bus.data        = data_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.frame_error = frame_error_q;
   assign bus.init_done   = init_done_q;

endmodule

// File: tb/tb_ps2mouse_host.sv
// Directed bench for ps2mouse_host: a simple PS/2 device model drives the
// open-drain lines, a monitor logs data_valid / frame_error pulses, and all
// expectations are hand-computed constants.
module tb_ps2mouse_host;

   localparam int Half = 25;  // device half clock period, in clk cycles

   logic clk;
   logic rst_n;
   logic dev_clk_low;
   logic dev_dat_low;

   int unsigned n_total;
   int unsigned n_bad;
   int unsigned dv_cnt;
   int unsigned fe_cnt;
   logic [7:0]  dv_log [$];

   ps2mouse_host_if bus ();

   assign bus.ps2clk_in = ~(dev_clk_low | bus.ps2clk_oe);
   assign bus.ps2dat_in = ~(dev_dat_low | bus.ps2dat_oe);

   ps2mouse_host #(
      .FILTER_LEN     (8),
      .INHIBIT_CYCLES (2800),
      .TIMEOUT_CYCLES (56000)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.data_valid) begin
         dv_cnt++;
         dv_log.push_back(bus.data);
      end
      if (bus.frame_error) fe_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One device-generated frame; nbits < 11 models a device that stalls.
   task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dev_dat_low = ~f[i];
         wait_cyc(Half);
         dev_clk_low = 1'b1;
         wait_cyc(Half);
         dev_clk_low = 1'b0;
      end
      dev_dat_low = 1'b0;
      wait_cyc(40);
   endtask

   // Measure the inhibit, then clock in the host command and ACK it.
   task automatic host_tx_phase();
      int         n;
      logic [9:0] seen;
      seen = '0;
      n = 0;
      while (!bus.ps2clk_oe && n < 200) begin
         n++;
         @(negedge clk);
      end
      check_eq("inhibit_start", bus.ps2clk_oe, 1);
      n = 0;
      while (bus.ps2clk_oe && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check_eq("inhibit_len", n, 2800);
      check_eq("req_dat_oe", bus.ps2dat_oe, 1);
      wait_cyc(30);
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         wait_cyc(Half);
         dev_clk_low = 1'b0;
         if (k <= 10) seen[k-1] = bus.ps2dat_in;
         if (k == 10) dev_dat_low = 1'b1;  // ACK
         wait_cyc(Half);
      end
      dev_dat_low = 1'b0;
      check_eq("tx_bits", seen, 10'h2F4);  // stop=1, parity=0, 0xF4 LSB first
      wait_cyc(20);
      check_eq("wait_ack_no_init", bus.init_done, 0);
   endtask

   initial begin
      int unsigned fe0, dv0, n;
      n_total     = 0;
      n_bad       = 0;
      dv_cnt      = 0;
      fe_cnt      = 0;
      rst_n       = 1'b0;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;

      wait_cyc(5);
      check_eq("rst_clk_oe", bus.ps2clk_oe, 0);
      check_eq("rst_dat_oe", bus.ps2dat_oe, 0);
      check_eq("rst_data", bus.data, 8'h00);
      check_eq("rst_valid", bus.data_valid, 0);
      check_eq("rst_ferr", bus.frame_error, 0);
      check_eq("rst_init", bus.init_done, 0);
      rst_n = 1'b1;

      host_tx_phase();

      wait_cyc(50);
      send_frame(8'hFA, 1'b0, 11);
      check_eq("ack_init_done", bus.init_done, 1);
      check_eq("ack_no_valid", dv_cnt, 0);
      check_eq("ack_no_ferr", fe_cnt, 0);

      send_frame(8'h08, 1'b0, 11);
      send_frame(8'h05, 1'b0, 11);
      send_frame(8'hFB, 1'b0, 11);
      check_eq("stream_cnt", dv_cnt, 3);
      if (dv_log.size() >= 3) begin
         check_eq("stream_b0", dv_log[0], 8'h08);
         check_eq("stream_b1", dv_log[1], 8'h05);
         check_eq("stream_b2", dv_log[2], 8'hFB);
      end

      fe0 = fe_cnt;
      dv0 = dv_cnt;
      send_frame(8'h09, 1'b1, 11);
      check_eq("badpar_ferr", fe_cnt - fe0, 1);
      check_eq("badpar_no_valid", dv_cnt - dv0, 0);
      check_eq("badpar_data_hold", bus.data, 8'hFB);
      send_frame(8'h09, 1'b0, 11);
      check_eq("good09_valid", dv_cnt - dv0, 1);
      check_eq("good09_data", bus.data, 8'h09);

      fe0 = fe_cnt;
      dv0 = dv_cnt;
      send_frame(8'h33, 1'b0, 4);
      wait_cyc(60000);
      check_eq("stall_ferr", fe_cnt - fe0, 1);
      check_eq("stall_no_valid", dv_cnt - dv0, 0);
      send_frame(8'h18, 1'b0, 11);
      check_eq("after_stall_valid", dv_cnt - dv0, 1);
      check_eq("after_stall_data", bus.data, 8'h18);
      check_eq("after_stall_ferr", fe_cnt - fe0, 1);

      dv0 = dv_cnt;
      send_frame(8'hAA, 1'b0, 11);
      check_eq("bat_init_low", bus.init_done, 0);
      check_eq("bat_no_valid", dv_cnt - dv0, 0);
      send_frame(8'h00, 1'b0, 11);
      check_eq("id_no_valid", dv_cnt - dv0, 0);
      n = 0;
      while (!bus.ps2clk_oe && n < 200) begin
         n++;
         @(negedge clk);
      end
      check_eq("reinit_clk_oe", bus.ps2clk_oe, 1);

      // Reset while the host is driving a 0 bit of the command.
      n = 0;
      while (bus.ps2clk_oe && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check_eq("reinit_req_dat_oe", bus.ps2dat_oe, 1);
      wait_cyc(30);
      for (int k = 0; k < 2; k++) begin
         dev_clk_low = 1'b1;
         wait_cyc(Half);
         dev_clk_low = 1'b0;
         wait_cyc(Half);
      end
      check_eq("tx_d1_dat_oe", bus.ps2dat_oe, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_clk_oe", bus.ps2clk_oe, 0);
      check_eq("async_rst_dat_oe", bus.ps2dat_oe, 0);
      check_eq("async_rst_data", bus.data, 8'h00);
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
